mux_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the 3-input registered priority mux.
- Three requesters compete for the mux; this block generates one-hot select lines sel1/sel2/sel3.
- It bounds each owner's tenure with a burst limit.
- It tracks the mux's 1-cycle latency so downstream logic knows when mux_op is valid and which source produced it.

---
 rtl/mux_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 26 ++
 rtl/mux_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam int unsigned NREQ = 3;

    typedef enum logic {IDLE, OWN} arb_state_t;

    typedef logic [1:0] src_t;

    // Encode a one-hot (or zero) grant vector as a source index; zero maps to 0.
    function automatic src_t onehot_to_src(input logic [NREQ-1:0] oh);
        case (oh)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [NREQ-1:0] src_to_onehot(input src_t s);
        return NREQ'(1) << s;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: examines ptr+1, ptr+2, ptr (mod NREQ).
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  src_t            ptr,
    output logic            found,
    output src_t            pick
);

    src_t idx;

    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = ptr;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = src_t'((32'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with burst limit driving a 3-input registered mux.
// Optional assertions are compiled in when MUX_ARB_SVA_EN is defined.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic            sel1,
    output logic            sel2,
    output logic            sel3,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            op_valid,
    output src_t            op_src
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    src_t             last_owner_q, last_owner_d;
    logic             op_valid_q, op_valid_d;
    src_t             op_src_q, op_src_d;

    logic found;
    src_t pick;

    // While owning, last_owner equals the current owner, so one search pointer serves both states.
    rr_pick u_pick (
        .req   (req),
        .ptr   (last_owner_q),
        .found (found),
        .pick  (pick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            burst_cnt_q  <= '0;
            last_owner_q <= 2'd2;
            op_valid_q   <= 1'b0;
            op_src_q     <= 2'd0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            burst_cnt_q  <= burst_cnt_d;
            last_owner_q <= last_owner_d;
            op_valid_q   <= op_valid_d;
            op_src_q     <= op_src_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        burst_cnt_d  = burst_cnt_q;
        last_owner_d = last_owner_q;
        // The mux output lags the grant by one edge.
        op_valid_d   = |gnt_q;
        op_src_d     = onehot_to_src(gnt_q);

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = OWN;
                    gnt_d        = src_to_onehot(pick);
                    burst_cnt_d  = CNT_W'(1);
                    last_owner_d = pick;
                end
            end
            OWN: begin
                if (req[last_owner_q] && (burst_cnt_q < CNT_W'(MAX_BURST))) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end else if (found) begin
                    gnt_d        = src_to_onehot(pick);
                    burst_cnt_d  = CNT_W'(1);
                    last_owner_d = pick;
                end else begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign gnt      = gnt_q;
    assign sel1     = gnt_q[0];
    assign sel2     = gnt_q[1];
    assign sel3     = gnt_q[2];
    assign busy     = |gnt_q;
    assign op_valid = op_valid_q;
    assign op_src   = op_src_q;

`ifdef MUX_ARB_SVA_EN
    a_gnt_onehot0: assert property (@(posedge clock) disable iff (reset) $onehot0(gnt))
        else $error("p_gnt_onehot0");

    a_op_valid: assert property (@(posedge clock) disable iff (reset) op_valid == $past(busy))
        else $error("p_op_valid");

    for (genvar i = 0; i < NREQ; i++) begin : g_sva
        a_gnt_req: assert property (@(posedge clock) disable iff (reset) gnt[i] |-> $past(req[i]))
            else $error("p_gnt_req");

        a_burst: assert property (@(posedge clock) disable iff (reset)
            not ((gnt[i] && ((req & ~(NREQ'(1) << i)) != '0)) [*MAX_BURST+1]))
            else $error("p_burst_bound");

        a_starve: assert property (@(posedge clock) disable iff (reset)
            req[i] |-> ##[1:2*MAX_BURST+1] (gnt[i] || !req[i]))
            else $error("p_no_starvation");
    end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter with a behavioural registered 3-input mux.
module tb_mux_rr_arbiter;
    import mux_arb_pkg::*;

    localparam int unsigned MB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req   = 3'b000;
    logic       sel1, sel2, sel3, busy, op_valid;
    logic [2:0] gnt;
    logic [1:0] op_src;

    logic [3:0] ip1 = 4'hA;
    logic [3:0] ip2 = 4'h5;
    logic [3:0] ip3 = 4'hC;
    logic [3:0] mux_op = 4'h0;
    logic [3:0] dtbl [3] = '{4'hA, 4'h5, 4'hC};

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        bit         is_op;
        logic [2:0] g;
        logic       ov;
        logic [1:0] os;
        logic [3:0] d;
    } exp_t;

    exp_t sb_q[$];

    mux_rr_arbiter #(.MAX_BURST(MB)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .sel1     (sel1),
        .sel2     (sel2),
        .sel3     (sel3),
        .gnt      (gnt),
        .busy     (busy),
        .op_valid (op_valid),
        .op_src   (op_src)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Registered priority mux: output at t+1 follows the selects at t.
    always @(posedge clock)
        mux_op <= sel1 ? ip1 : sel2 ? ip2 : sel3 ? ip3 : mux_op;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Apply req for one cycle; grant is expected next cycle, mux output the cycle after.
    task automatic drive(input logic [2:0] r, input logic [2:0] eg);
        exp_t e;
        @(posedge clock);
        #1;
        req = r;
        e.cyc = cyc + 1; e.is_op = 1'b0; e.g = eg; e.ov = 1'b0; e.os = 2'd0; e.d = 4'h0;
        sb_q.push_back(e);
        e.cyc   = cyc + 2;
        e.is_op = 1'b1;
        e.ov    = (eg != 3'b000);
        e.os    = (eg == 3'b010) ? 2'd1 : (eg == 3'b100) ? 2'd2 : 2'd0;
        e.d     = e.ov ? dtbl[e.os] : 4'h0;
        sb_q.push_back(e);
    endtask

    // Monitor: pops every expectation due this cycle.
    always @(negedge clock) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_expectation: due cycle %0d, now %0d", e.cyc, cyc);
            end else if (!e.is_op) begin
                chk("gnt", gnt, e.g);
                chk("busy", busy, e.g != 3'b000);
                chk("sel", {sel3, sel2, sel1}, e.g);
            end else begin
                chk("op_valid", op_valid, e.ov);
                chk("op_src", op_src, e.os);
                if (e.ov) chk("mux_op", mux_op, e.d);
            end
        end
        if (!reset) chk("gnt_onehot0", $onehot0(gnt), 1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clock);
        #1;
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sel", {sel3, sel2, sel1}, 3'b000);
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_op_src", op_src, 2'd0);
        @(negedge clock);
        reset = 1'b0;

        // Lone requester 0: granted next cycle and re-granted across burst boundaries
        drive(3'b000, 3'b000);
        repeat (10) drive(3'b001, 3'b001);
        drive(3'b000, 3'b000);

        // last_owner=0, req=101: requester 2 wins, then rotates to 0 after MB cycles
        repeat (MB) drive(3'b101, 3'b100);
        drive(3'b101, 3'b001);
        drive(3'b000, 3'b000);

        // Owner 1 drops while 2 waits: direct hand-over, no idle cycle
        drive(3'b010, 3'b010);
        drive(3'b110, 3'b010);
        drive(3'b100, 3'b100);
        drive(3'b100, 3'b100);
        drive(3'b000, 3'b000);

        // All requesting; reset lands in the middle of the 010 burst
        for (int k = 0; k < 6; k++) drive(3'b111, 3'b001 << ((k / MB) % 3));
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_gnt", gnt, 3'b000);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_op_valid", op_valid, 1'b0);
        chk("midrst_op_src", op_src, 2'd0);
        sb_q.delete();
        req = 3'b000;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Full rotation 0,1,2 in MB-cycle runs, with mux data following op_src
        for (int k = 0; k < 30; k++) drive(3'b111, 3'b001 << ((k / MB) % 3));
        drive(3'b000, 3'b000);

        repeat (3) @(negedge clock);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
